// File: rtl/boot_ctl.sv
`default_nettype none

`ifndef ADR_WIDTH
`define ADR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// ============================================================================
// Module   : boot_ctl
// Purpose  : Boot and program-load sequencer for the accumulator core.
//            Holds the core in reset while a program image is streamed into
//            the shared program/data RAM over a valid/ready port, waits a
//            short drain period, then releases the core. Owns the RAM bus mux:
//            the loader drives the RAM while loading, the core while running.
//            A reload can be requested at any time while the core runs.
//
// Ports    : clk_i          system clock, rising edge
//            rst_i          synchronous active-high reset
//            start_i        reload request (honoured only while running)
//            load_data_i    program word from the loader source
//            load_valid_i   load_data_i valid
//            load_last_i    final word of the image (qualified by valid)
//            load_ready_o   a word is accepted this cycle
//            core_rst_o     registered reset to the core
//            core_adr_i     core address
//            core_data_i    core write data
//            core_we_i      core write enable
//            mem_adr_o      RAM address
//            mem_data_o     RAM write data
//            mem_we_o       RAM write enable
//            busy_o         high while loading or draining
//            words_o        words written by the last/current load
//            err_o          sticky: image exceeded 2^ADR_WIDTH words
//
// Revision : 1.0  initial release
// ============================================================================

module boot_ctl #(
  parameter int ADR_WIDTH     = `ADR_WIDTH,
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  core_rst_o,
  input  logic [ADR_WIDTH-1:0]  core_adr_i,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  input  logic                  core_we_i,
  output logic [ADR_WIDTH-1:0]  mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  busy_o,
  output logic [ADR_WIDTH:0]    words_o,
  output logic                  err_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The drain counter is 4 bits wide, enough for the supported 1..15 range.
  localparam int         c_dly_w    = 4;
  localparam logic [3:0] c_dly_last = 4'(RELEASE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam state_t     c_rst_state = BOOT_ON_RESET ? ST_LOAD : ST_RUN;
  localparam logic       c_rst_core  = BOOT_ON_RESET;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  state_t                r_state,    w_state_nxt;
  logic [ADR_WIDTH-1:0]  r_wr_ptr,   w_wr_ptr_nxt;
  logic [ADR_WIDTH:0]    r_words,    w_words_nxt;
  logic                  r_err,      w_err_nxt;
  logic [c_dly_w-1:0]    r_dly,      w_dly_nxt;
  logic                  r_core_rst, w_core_rst_nxt;

  // Accepted loader beat. Reset masks ready, so no beat can land while rst_i
  // is high even if the state register still reads LOAD.
  logic                  w_ready;
  logic                  w_beat;

  assign w_ready = (r_state == ST_LOAD) && !rst_i;
  assign w_beat  = w_ready && load_valid_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= c_rst_state;
      r_wr_ptr   <= '0;
      r_words    <= '0;
      r_err      <= 1'b0;
      r_dly      <= '0;
      r_core_rst <= c_rst_core;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_words    <= w_words_nxt;
      r_err      <= w_err_nxt;
      r_dly      <= w_dly_nxt;
      r_core_rst <= w_core_rst_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_words_nxt    = r_words;
    w_err_nxt      = r_err;
    w_dly_nxt      = r_dly;
    w_core_rst_nxt = r_core_rst;

    unique case (r_state)
      ST_LOAD: begin
        if (w_beat) begin
          // Pointer wraps naturally; the wrap is only reached on overflow,
          // and then the state leaves LOAD so address 0 is never rewritten.
          w_wr_ptr_nxt = r_wr_ptr + ADR_WIDTH'(1);
          w_words_nxt  = r_words + (ADR_WIDTH + 1)'(1);
          if (load_last_i) begin
            w_state_nxt = ST_DRAIN;
          end else if (&r_wr_ptr) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // The counter starts at 0 on the last-write edge, so the core is
        // released exactly RELEASE_DELAY edges after that write.
        if (r_dly == c_dly_last) begin
          w_dly_nxt      = '0;
          w_state_nxt    = ST_RUN;
          w_core_rst_nxt = 1'b0;
        end else begin
          w_dly_nxt = r_dly + c_dly_w'(1);
        end
      end

      ST_RUN: begin
        if (start_i) begin
          w_state_nxt    = ST_LOAD;
          w_wr_ptr_nxt   = '0;
          w_words_nxt    = '0;
          w_err_nxt      = 1'b0;
          w_dly_nxt      = '0;
          w_core_rst_nxt = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover into a safe, held-in-reset load.
        w_state_nxt    = ST_LOAD;
        w_wr_ptr_nxt   = '0;
        w_words_nxt    = '0;
        w_err_nxt      = 1'b0;
        w_dly_nxt      = '0;
        w_core_rst_nxt = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory bus mux
  // --------------------------------------------------------------------------
  // Loader owns the bus in LOAD, nobody in DRAIN, the core in RUN. Since the
  // mux follows the registered state, the cycle in which start_i is sampled
  // still belongs to the core; from the next cycle core writes are blocked.
  always_comb begin
    mem_adr_o  = '0;
    mem_data_o = '0;
    mem_we_o   = 1'b0;

    unique case (r_state)
      ST_LOAD: begin
        mem_adr_o  = r_wr_ptr;
        mem_data_o = w_beat ? load_data_i : '0;
        mem_we_o   = w_beat;
      end
      ST_RUN: begin
        mem_adr_o  = core_adr_i;
        mem_data_o = core_data_i;
        mem_we_o   = core_we_i && !rst_i;
      end
      default: begin
        mem_adr_o  = '0;
        mem_data_o = '0;
        mem_we_o   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign load_ready_o = w_ready;
  assign core_rst_o   = r_core_rst;
  assign busy_o       = (r_state != ST_RUN);
  assign words_o      = r_words;
  assign err_o        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_boot_ctl.sv
`default_nettype none

// ============================================================================
// Module   : tb_boot_ctl
// Purpose  : Self-checking bench for boot_ctl. Two instances share stimulus:
//            one boots into LOAD (release delay 2), one starts in RUN
//            (release delay 3). Each cycle every output of both instances is
//            compared with a behavioural model kept in the bench.
// Revision : 1.0  initial release
// ============================================================================

module tb_boot_ctl;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int RD_B = 2;
  localparam int RD_R = 3;
  localparam int DEPTH = 1 << AW;

  localparam int PH_LOAD  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_RUN   = 2;

  logic          clk = 1'b0;
  logic          rst, start, ld_valid, ld_last, core_we;
  logic [DW-1:0] ld_data, core_data;
  logic [AW-1:0] core_adr;

  logic          rdy_b, crst_b, we_b, busy_b, err_b;
  logic [AW-1:0] adr_b;
  logic [DW-1:0] dat_b;
  logic [AW:0]   words_b;

  logic          rdy_r, crst_r, we_r, busy_r, err_r;
  logic [AW-1:0] adr_r;
  logic [DW-1:0] dat_r;
  logic [AW:0]   words_r;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  boot_ctl #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_ON_RESET(1'b1), .RELEASE_DELAY(RD_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .load_data_i(ld_data), .load_valid_i(ld_valid), .load_last_i(ld_last),
    .load_ready_o(rdy_b), .core_rst_o(crst_b),
    .core_adr_i(core_adr), .core_data_i(core_data), .core_we_i(core_we),
    .mem_adr_o(adr_b), .mem_data_o(dat_b), .mem_we_o(we_b),
    .busy_o(busy_b), .words_o(words_b), .err_o(err_b)
  );

  boot_ctl #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_ON_RESET(1'b0), .RELEASE_DELAY(RD_R)) dut_r (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .load_data_i(ld_data), .load_valid_i(ld_valid), .load_last_i(ld_last),
    .load_ready_o(rdy_r), .core_rst_o(crst_r),
    .core_adr_i(core_adr), .core_data_i(core_data), .core_we_i(core_we),
    .mem_adr_o(adr_r), .mem_data_o(dat_r), .mem_we_o(we_r),
    .busy_o(busy_r), .words_o(words_r), .err_o(err_r)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: phase, words written so far, overflow flag and the
  // number of edges left before the core is released. The write address is
  // simply the count of words taken into the current image.
  // --------------------------------------------------------------------------
  int m_ph[2];
  int m_words[2];
  int m_err[2];
  int m_left[2];
  int m_boot[2] = '{1, 0};
  int m_rd[2]   = '{RD_B, RD_R};
  logic [DW-1:0] m_image[2][$];

  task automatic model_reset(input int i);
    m_ph[i]    = m_boot[i] ? PH_LOAD : PH_RUN;
    m_words[i] = 0;
    m_err[i]   = 0;
    m_left[i]  = 0;
    m_image[i].delete();
  endtask

  task automatic check_and_step(input int i);
    string  nm;
    bit     ready, beat;
    int     e_adr, e_dat, e_we;
    logic [31:0] o_rdy, o_crst, o_we, o_busy, o_err, o_adr, o_dat, o_words;

    nm    = (i == 0) ? "b" : "r";
    ready = (m_ph[i] == PH_LOAD) && !rst;
    beat  = ready && ld_valid;
    case (m_ph[i])
      PH_LOAD: begin
        e_adr = m_words[i] % DEPTH;
        e_dat = beat ? int'(ld_data) : 0;
        e_we  = beat;
      end
      PH_RUN: begin
        e_adr = core_adr;
        e_dat = core_data;
        e_we  = core_we && !rst;
      end
      default: begin
        e_adr = 0; e_dat = 0; e_we = 0;
      end
    endcase

    if (i == 0) begin
      o_rdy = 32'(rdy_b); o_crst = 32'(crst_b); o_we = 32'(we_b); o_busy = 32'(busy_b);
      o_err = 32'(err_b); o_adr = 32'(adr_b); o_dat = 32'(dat_b); o_words = 32'(words_b);
    end else begin
      o_rdy = 32'(rdy_r); o_crst = 32'(crst_r); o_we = 32'(we_r); o_busy = 32'(busy_r);
      o_err = 32'(err_r); o_adr = 32'(adr_r); o_dat = 32'(dat_r); o_words = 32'(words_r);
    end

    chk({nm, ".ready"},    o_rdy,   32'(ready));
    chk({nm, ".we"},       o_we,    32'(e_we));
    chk({nm, ".adr"},      o_adr,   32'(e_adr));
    chk({nm, ".data"},     o_dat,   32'(e_dat));
    chk({nm, ".core_rst"}, o_crst,  32'(m_ph[i] != PH_RUN));
    chk({nm, ".busy"},     o_busy,  32'(m_ph[i] != PH_RUN));
    chk({nm, ".words"},    o_words, 32'(m_words[i]));
    chk({nm, ".err"},      o_err,   32'(m_err[i]));

    // Advance the model across the coming edge.
    if (rst) begin
      model_reset(i);
    end else begin
      case (m_ph[i])
        PH_LOAD: if (beat) begin
          m_image[i].push_back(ld_data);
          m_words[i]++;
          if (ld_last) begin
            m_ph[i] = PH_DRAIN; m_left[i] = m_rd[i];
          end else if (m_words[i] == DEPTH) begin
            m_err[i] = 1; m_ph[i] = PH_DRAIN; m_left[i] = m_rd[i];
          end
        end
        PH_DRAIN: begin
          m_left[i]--;
          if (m_left[i] == 0) m_ph[i] = PH_RUN;
        end
        default: if (start) begin
          m_ph[i] = PH_LOAD; m_words[i] = 0; m_err[i] = 0;
          m_image[i].delete();
        end
      endcase
    end
  endtask

  // One clock: compare at the falling edge, step the model, then return just
  // after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    check_and_step(0);
    check_and_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cycle();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; core_adr = '0; core_data = '0; core_we = 1'b0;
    @(posedge clk);
    #1;
    model_reset(0);
    model_reset(1);

    // Boot: one reset cycle, then a 4-word image.
    cycle();
    rst = 1'b0;
    chk("boot.rst_core_r", 32'(crst_r), 32'd0);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    chk("boot.words", 32'(words_b), 32'd4);
    chk("boot.err",   32'(err_b),   32'd0);
    chk("boot.hold0", 32'(crst_b),  32'd1);
    cycle();
    chk("boot.hold1", 32'(crst_b),  32'd1);
    cycle();
    chk("boot.release", 32'(crst_b), 32'd0);
    chk("boot.busy",    32'(busy_b), 32'd0);

    // Gapped stream: valid 1,0,0,1,1(last).
    idle(2);
    pulse_start();
    beat(8'hA1, 1'b0);
    idle(2);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b1);
    chk("gap.words", 32'(words_b), 32'd3);

    // Core pass-through while running.
    idle(4);
    core_adr = 4'h5; core_data = 8'hAB; core_we = 1'b1;
    #1;
    chk("run.adr",   32'(adr_b), 32'h5);
    chk("run.data",  32'(dat_b), 32'hAB);
    chk("run.we",    32'(we_b),  32'd1);
    chk("run.ready", 32'(rdy_b), 32'd0);
    cycle();

    // Reload requested while the core is writing.
    pulse_start();
    chk("reload.core_rst", 32'(crst_b),  32'd1);
    chk("reload.words",    32'(words_b), 32'd0);
    chk("reload.we_block", 32'(we_b),    32'd0);
    core_we = 1'b0;
    beat(8'h5A, 1'b0);
    beat(8'h5B, 1'b1);
    chk("reload.words2", 32'(words_b), 32'd2);

    // Overflow: 17 beats, no last.
    idle(4);
    pulse_start();
    for (int k = 0; k < DEPTH; k++) beat(8'(k + 8'h30), 1'b0);
    chk("ovf.err",   32'(err_b),   32'd1);
    chk("ovf.words", 32'(words_b), 32'(DEPTH));
    chk("ovf.ready", 32'(rdy_b),   32'd0);
    beat(8'hEE, 1'b0);
    idle(3);
    chk("ovf.run", 32'(busy_b), 32'd0);

    // Reset in the middle of a load.
    idle(2);
    pulse_start();
    beat(8'h61, 1'b0);
    beat(8'h62, 1'b0);
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h63;
    #1;
    chk("midrst.we",    32'(we_b),  32'd0);
    chk("midrst.ready", 32'(rdy_b), 32'd0);
    cycle();
    rst = 1'b0; ld_valid = 1'b0;
    chk("midrst.words",  32'(words_b), 32'd0);
    chk("midrst.r_run",  32'(crst_r),  32'd0);
    chk("midrst.r_busy", 32'(busy_r),  32'd0);
    beat(8'h71, 1'b0);
    beat(8'h72, 1'b0);
    beat(8'h73, 1'b1);
    chk("midrst.image", 32'(m_image[0].size()), 32'd3);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 19) == 0);
      ld_valid  = $urandom_range(0, 1);
      ld_last   = ($urandom_range(0, 9) == 0);
      ld_data   = DW'($urandom);
      core_adr  = AW'($urandom);
      core_data = DW'($urandom);
      core_we   = $urandom_range(0, 1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/boot_ctl.md
Name: boot_ctl

Overview:
- Boot and program-load sequencer for the accumulator core.
- Holds the core in reset while it streams a program image into the shared program/data memory over a valid/ready port, then releases the core.
- Owns the memory bus mux: the loader drives memory while loading, the core drives it while running.
- Sits between the core's memory port (adr/data/we) and the single-port RAM; a reload can be requested at any time while the core runs.

Parameters:
ADR_WIDTH, `ADR_WIDTH, memory/core address width in bits.
DATA_WIDTH, `DATA_WIDTH, memory/core data word width in bits.
BOOT_ON_RESET, 1, 1: enter LOAD after rst_i; 0: enter RUN directly (pre-initialised memory).
RELEASE_DELAY, 2, cycles core_rst_o stays high in DRAIN after the last write (range 1..15).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  reload request; sampled only in RUN.
- load_data_i  in  DATA_WIDTH  program word from the loader source.
- load_valid_i  in  1  load_data_i valid.
- load_last_i  in  1  qualifies the final word of an image; meaningful only with load_valid_i.
- load_ready_o  out  1  controller accepts a word this cycle.
- core_rst_o  out  1  reset to the core; registered.
- core_adr_i  in  ADR_WIDTH  core address output.
- core_data_i  in  DATA_WIDTH  core write data.
- core_we_i  in  1  core write enable.
- mem_adr_o  out  ADR_WIDTH  memory address.
- mem_data_o  out  DATA_WIDTH  memory write data.
- mem_we_o  out  1  memory write enable.
- busy_o  out  1  high in LOAD and DRAIN.
- words_o  out  ADR_WIDTH+1  number of words written by the last/current load.
- err_o  out  1  sticky overflow: image exceeded 2^ADR_WIDTH words.

Behaviour:
- States: LOAD, DRAIN, RUN. State, wr_ptr, words_o, err_o, delay counter and core_rst_o are registers.
- rst_i (any state, mid-load included):
  - state <= LOAD if BOOT_ON_RESET else RUN.
  - wr_ptr <= 0, words_o <= 0, err_o <= 0, delay counter <= 0.
  - core_rst_o <= 1 if BOOT_ON_RESET else 0.
  - Memory contents are not touched.
- While rst_i is high, mem_we_o = 0 and load_ready_o = 0 (combinational override).
- core_rst_o is 1 in LOAD and DRAIN, 0 in RUN. It is registered, so it changes on the same edge as the state.
- LOAD:
  - load_ready_o = 1.
  - On an accepted beat (load_valid_i & load_ready_o), same cycle, combinational: mem_we_o = 1, mem_adr_o = wr_ptr, mem_data_o = load_data_i.
  - With no beat: mem_we_o = 0, mem_adr_o = wr_ptr, mem_data_o = 0.
  - On each accepted beat: wr_ptr <= wr_ptr + 1 (wraps at 2^ADR_WIDTH) and words_o <= words_o + 1.
  - Accepted beat with load_last_i = 1 -> DRAIN.
  - Accepted beat at wr_ptr = all-ones with load_last_i = 0: the word is written, err_o <= 1, state -> DRAIN. The next word would overwrite address 0 and is never accepted.
  - load_last_i without load_valid_i is ignored.
- DRAIN:
  - load_ready_o = 0, mem_we_o = 0, mem_adr_o = 0, mem_data_o = 0.
  - Delay counter counts 0..RELEASE_DELAY-1; at RELEASE_DELAY-1 -> RUN and the counter clears.
  - core_rst_o therefore falls exactly RELEASE_DELAY cycles after the last-write edge.
- RUN:
  - load_ready_o = 0.
  - mem_adr_o = core_adr_i, mem_data_o = core_data_i, mem_we_o = core_we_i (pure combinational pass-through, zero latency).
  - start_i = 1 -> LOAD on the next edge, with wr_ptr <= 0, words_o <= 0, err_o <= 0, core_rst_o <= 1.
  - In the cycle start_i is sampled, the core still owns the bus.
  - From the next cycle, core_we_i is blocked by the mux, so a core write can never land during a load.
- start_i is ignored in LOAD and DRAIN. A simultaneous start_i and rst_i resolves as reset.
- Zero-length image: impossible by protocol; load_last_i is only honoured with a valid beat, so at least one word is written.
- load_data_i / load_last_i may change freely while load_valid_i = 0. The source must hold them stable while valid is high and ready is low (ready is never low in LOAD, so every valid beat in LOAD is accepted).
- busy_o = (state != RUN).

Test Plan:
- Boot, BOOT_ON_RESET=1, RELEASE_DELAY=2: rst_i 1 cycle, then 4 valid beats 0x11,0x22,0x33,0x44 (last on the 4th) -> mem writes at adr 0..3 in the beat cycles; words_o=4; err_o=0; core_rst_o falls 2 cycles after the 4th write edge; busy_o=0 at the same time.
- Gapped stream: valid toggled 1,0,0,1,1(last) -> exactly 3 writes at adr 0,1,2; mem_we_o=0 in the idle cycles; no address skips.
- RUN pass-through: drive core_adr_i=0x05, core_data_i=0xAB, core_we_i=1 -> same-cycle mem_adr_o=0x05, mem_data_o=0xAB, mem_we_o=1; load_ready_o=0.
- Reload: start_i pulse in RUN while core_we_i=1 -> next cycle core_rst_o=1, mem_we_o follows loader only, words_o=0; a 2-word image then writes adr 0,1.
- Overflow, ADR_WIDTH=4: stream 17 valid beats with no last -> 16 writes to adr 0..15; err_o=1 after the 16th; the 17th beat is not accepted (ready=0); RUN is reached after RELEASE_DELAY.
- Reset mid-load: rst_i asserted after 2 of 5 beats -> mem_we_o=0 during reset; words_o=0; a restarted load writes from adr 0. With BOOT_ON_RESET=0, the state goes to RUN and core_rst_o=0 one cycle after rst_i falls.
